// File: rtl/ram_master.sv
// rtl/ram_master.sv - initiator-side controller for a 16x8 single-port synchronous RAM
//
// Optional array fill after reset is compiled in with `define RAM_MASTER_INIT_EN.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   req_valid/ready    client request handshake; req_ready is combinational from state
//   req_we             1 = write, 0 = read
//   req_addr/wdata     request address / write data
//   rsp_valid          one-cycle strobe marking fresh read data on rsp_rdata
//   rsp_rdata          read data, held until the next read response
//   init_start         pulse in IDLE starts the array fill (feature build only)
//   init_busy          fill in progress (tied low without the feature)
//   ram_we/addr/din    registered RAM controls
//   ram_dout           RAM read data, valid one cycle after the address edge
module ram_master #(
  parameter int                ADDR_W     = 4,
  parameter int                DATA_W     = 8,
  parameter int                DEPTH      = 16,
  parameter logic [DATA_W-1:0] INIT_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              init_start,
  output logic              init_busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    RD_CAP = 2'd2,
    INIT   = 2'd3
  } state_t;

  state_t state;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef RAM_MASTER_INIT_EN
  // A fill request in IDLE takes priority over a client request in the same cycle.
  assign req_ready = (state == IDLE) && !init_start;
`else
  assign req_ready = (state == IDLE);
  assign init_busy = 1'b0;
  wire unused_cfg = ^{init_start, LAST_ADDR, INIT_VALUE};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef RAM_MASTER_INIT_EN
      init_busy <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          ram_we <= 1'b0;
`ifdef RAM_MASTER_INIT_EN
          if (init_start) begin
            // First fill write is issued on the same edge that enters INIT.
            state     <= INIT;
            init_busy <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= '0;
            ram_din   <= INIT_VALUE;
          end
`endif
          if (req_valid && req_ready) begin
            ram_addr <= req_addr;
            if (req_we) begin
              ram_we  <= 1'b1;
              ram_din <= req_wdata;
            end else begin
              state <= RD_MEM;
            end
          end
        end
        RD_MEM: begin
          // RAM registers dataout on this edge.
          ram_we <= 1'b0;
          state  <= RD_CAP;
        end
        RD_CAP: begin
          rsp_rdata <= ram_dout;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
`ifdef RAM_MASTER_INIT_EN
        INIT: begin
          if (ram_addr == LAST_ADDR) begin
            ram_we    <= 1'b0;
            init_busy <= 1'b0;
            state     <= IDLE;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
        end
`endif
        default: begin
          ram_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - scoreboard bench for ram_master with a behavioural 16x8 RAM
module tb_ram_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       init_start, init_busy;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem    [16];
  logic [7:0] shadow [16];
  logic [7:0] exp_q  [$];

  always #5 clk = ~clk;

  ram_master #(
    .ADDR_W(4), .DATA_W(8), .DEPTH(16), .INIT_VALUE(8'h5A)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .init_start(init_start), .init_busy(init_busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Single-port RAM, registered read, read-old-data on a same-address write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every response strobe must match the oldest expected read.
  always @(negedge clk) begin
    if (rst === 1'b1 && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 data %0h expected no response at %0t",
                 rsp_rdata, $time);
      end else begin
        chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    chk("wr_ready", req_ready, 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    shadow[a] = d;
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, a);
    chk("wr_ram_din", ram_din, d);
  endtask

  task automatic rd(input logic [3:0] a);
    chk("rd_ready", req_ready, 1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    exp_q.push_back(shadow[a]);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rd_busy1", req_ready, 0);
    chk("rd_ram_we", ram_we, 0);
    @(posedge clk); #1;
    chk("rd_busy2", req_ready, 0);
    @(posedge clk); #1;
    chk("rd_latency", rsp_valid, 1);
    chk("rd_ready_back", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    init_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_init_busy", init_busy, 0);
    chk("rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    chk("idle_ram_we", ram_we, 0);

    // Write then read on consecutive accepts
    wr(4'h3, 8'hA5);
    rd(4'h3);
    @(posedge clk); #1;
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("rsp_held", rsp_rdata, 8'hA5);

    // Burst of 16 back-to-back writes
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h10 + 8'(i));
    @(posedge clk); #1;
    chk("burst_idle_we", ram_we, 0);
    chk("burst_addr_hold", ram_addr, 4'hF);
    rd(4'h0);
    rd(4'hF);
    wr(4'h7, 8'hC3);
    rd(4'h7);

    // Reset during RD_MEM drops the read
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_no_rsp", rsp_valid, 0);
    end
    chk("mid_rst_rdata", rsp_rdata, 0);
    chk("mid_rst_ready", req_ready, 1);

`ifdef RAM_MASTER_INIT_EN
    // Fill wins over a simultaneous request
    init_start = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h2;
    #1 chk("init_blocks_req", req_ready, 0);
    @(posedge clk); #1;
    init_start = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("init_busy", init_busy, 1);
      chk("init_ram_we", ram_we, 1);
      chk("init_ram_addr", ram_addr, i);
      chk("init_ram_din", ram_din, 8'h5A);
      chk("init_not_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    chk("init_done_busy", init_busy, 0);
    chk("init_done_we", ram_we, 0);
    chk("init_done_ready", req_ready, 1);
    for (int i = 0; i < 16; i++) shadow[i] = 8'h5A;
    rd(4'h9);
`else
    // Without the fill feature init_start has no effect
    init_start = 1'b1;
    #1 chk("noinit_ready", req_ready, 1);
    @(posedge clk); #1;
    init_start = 1'b0;
    repeat (3) begin
      chk("noinit_busy", init_busy, 0);
      chk("noinit_we", ram_we, 0);
      chk("noinit_ready_hold", req_ready, 1);
      @(posedge clk); #1;
    end
    rd(4'h3);
`endif

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1 chk("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
